// File: rtl/mux_stream_sel.sv
// NUM_IN-way stream selector with a single registered output stage.
// Directed (sel) or round-robin arbitration; sticky error on an out-of-range sel.
module mux_stream_sel #(
    parameter int WIDTH  = 128,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    input  logic                    out_ready,
    input  logic                    clr_err,
    output logic                    sel_err
);

    localparam logic [SEL_W:0] NUM_IN_L = NUM_IN[SEL_W:0];

    logic [WIDTH-1:0]  in_arr [NUM_IN];
    logic [SEL_W-1:0]  ptr_reg;
    logic [SEL_W-1:0]  rr_g;
    logic              rr_found;
    logic [SEL_W-1:0]  g;
    logic              grant_ok;
    logic              sel_ok;
    logic              load;
    logic              transfer;
    logic [SEL_W:0]    idx;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
        assign in_arr[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    assign sel_ok = ({1'b0, sel} < NUM_IN_L);
    assign load   = !out_valid || out_ready;

    // Search ptr+1, ptr+2, ... (mod NUM_IN); the first valid input wins.
    always_comb begin
        rr_g     = '0;
        rr_found = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = {1'b0, ptr_reg} + k[SEL_W:0];
            if (idx >= NUM_IN_L)
                idx = idx - NUM_IN_L;
            if (!rr_found && in_valid[idx[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_g     = idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        if (mode) begin
            g        = rr_g;
            grant_ok = rr_found;
        end else begin
            g        = sel;
            grant_ok = sel_ok;
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && grant_ok && load)
            in_ready[g] = 1'b1;
    end

    assign transfer = grant_ok && in_valid[g] && in_ready[g];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr_reg   <= SEL_W'(NUM_IN - 1);
        end else begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= in_arr[g];
                out_src   <= g;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Only round-robin grants advance the pointer.
            if (transfer && mode)
                ptr_reg <= g;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sel_err <= 1'b0;
        else if (!mode && !sel_ok)
            sel_err <= 1'b1;
        else if (clr_err)
            sel_err <= 1'b0;
    end

endmodule

// File: tb/tb_mux_stream_sel.sv
// Directed-vector bench for mux_stream_sel (WIDTH=128, NUM_IN=3).
module tb_mux_stream_sel;

    localparam int WIDTH  = 128;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_ready;
    logic                    clr_err;
    logic                    sel_err;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [WIDTH-1:0] A5 = {16{8'hA5}};

    mux_stream_sel #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .clr_err(clr_err), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] v);
        in_data[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        int rr_exp [6];
        rr_exp = '{0, 1, 2, 0, 1, 2};

        rst_n = 1'b0; mode = 1'b0; sel = 3'd1; in_valid = 3'b010;
        in_data = '0; out_ready = 1'b1; clr_err = 1'b0;
        set_data(1, A5);
        #12;
        check_val("rst out_valid", WIDTH'(out_valid), '0);
        check_val("rst out_data", out_data, '0);
        check_val("rst out_src", WIDTH'(out_src), '0);
        check_val("rst sel_err", WIDTH'(sel_err), '0);
        check_val("rst in_ready", WIDTH'(in_ready), '0);
        rst_n = 1'b1;
        #1;

        // Directed pass-through
        check_val("dir in_ready", WIDTH'(in_ready), WIDTH'(3'b010));
        step();
        check_val("dir out_valid", WIDTH'(out_valid), 1);
        check_val("dir out_data", out_data, A5);
        check_val("dir out_src", WIDTH'(out_src), 1);

        // Backpressure: output must hold while in_data moves
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_data(1, WIDTH'(i + 16'h100));
            #1;
            check_val("bp in_ready", WIDTH'(in_ready), '0);
            step();
            check_val("bp out_data", out_data, A5);
            check_val("bp out_valid", WIDTH'(out_valid), 1);
        end
        out_ready = 1'b1;
        set_data(1, WIDTH'(16'h1234));
        #1;
        check_val("drain in_ready", WIDTH'(in_ready), WIDTH'(3'b010));
        step();
        check_val("refill out_data", out_data, WIDTH'(16'h1234));
        check_val("refill out_valid", WIDTH'(out_valid), 1);

        // Bad select
        sel = 3'd5; in_valid = 3'b111;
        #1;
        check_val("bad in_ready", WIDTH'(in_ready), '0);
        step();
        check_val("bad out_valid", WIDTH'(out_valid), 0);
        check_val("bad out_data hold", out_data, WIDTH'(16'h1234));
        check_val("bad sel_err", WIDTH'(sel_err), 1);
        step();
        check_val("bad sel_err sticky", WIDTH'(sel_err), 1);
        sel = 3'd0; clr_err = 1'b1; in_valid = 3'b000;
        step();
        clr_err = 1'b0;
        check_val("clr sel_err", WIDTH'(sel_err), 0);
        check_val("clr out_valid", WIDTH'(out_valid), 0);

        // Round-robin fairness from reset
        rst_n = 1'b0;
        mode = 1'b1; in_valid = 3'b111;
        set_data(0, WIDTH'(16'hD0)); set_data(1, WIDTH'(16'hD1)); set_data(2, WIDTH'(16'hD2));
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val($sformatf("rr src[%0d]", i), WIDTH'(out_src), WIDTH'(rr_exp[i]));
        end
        check_val("rr out_data", out_data, WIDTH'(16'hD2));
        step();
        check_val("rr wrap src", WIDTH'(out_src), 0);

        // Skip and wrap with ptr=0
        in_valid = 3'b101;
        step(); check_val("skip src a", WIDTH'(out_src), 2);
        step(); check_val("skip src b", WIDTH'(out_src), 0);
        step(); check_val("skip src c", WIDTH'(out_src), 2);
        in_valid = 3'b000;
        step();
        check_val("idle out_valid", WIDTH'(out_valid), 0);
        check_val("idle out_src hold", WIDTH'(out_src), 2);
        in_valid = 3'b011;
        #1;
        check_val("ptr hold in_ready", WIDTH'(in_ready), WIDTH'(3'b001));

        // Async reset mid-stall
        in_valid = 3'b111; out_ready = 1'b0;
        step();
        check_val("stall out_valid", WIDTH'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check_val("async out_valid", WIDTH'(out_valid), 0);
        check_val("async in_ready", WIDTH'(in_ready), '0);
        #2;
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check_val("post-rst in_ready", WIDTH'(in_ready), WIDTH'(3'b001));
        step();
        check_val("post-rst out_valid", WIDTH'(out_valid), 1);
        check_val("post-rst out_src", WIDTH'(out_src), 0);
        check_val("post-rst out_data", out_data, WIDTH'(16'hD0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
